display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 NUM_DIGITS, 2, number of multiplexed digits; legal 2..4.
REQ-002 DIV_COUNT, 60000, clk cycles each digit is shown per scan slot; legal >= 2.
REQ-003 BLANK_CYCLES, 600, clk cycles with all digits off between slots (anti-ghosting); legal >= 1.
REQ-004 clk  input  1  single clock, e.g. 6 MHz HSOSC output.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  scanning enabled when high.
REQ-007 digits_in  input  4*NUM_DIGITS  new digit values; nibble k drives digit k.
REQ-008 load_valid  input  1  digits_in valid this cycle.
REQ-009 load_ready  output  1  pending buffer empty; load accepted when load_valid && load_ready.
REQ-010 seg_code  output  4  nibble for the external seven-segment decoder.
REQ-011 digit_en  output  NUM_DIGITS  active-high one-hot digit enables.
REQ-012 frame_start  output  1  one-cycle pulse on first SHOW cycle of digit 0.

Function
REQ-013 States: IDLE, SHOW, BLANK; Moore outputs decoded from registered state, index, and active buffer.
REQ-014 IDLE: digit_en = 0, seg_code = 0, counter held at 0, index = 0.
REQ-015 IDLE -> SHOW(index 0) on the first clk edge with enable = 1; frame boundary.
REQ-016 SHOW: digit_en = onehot(index), seg_code = active nibble[index]; lasts exactly DIV_COUNT cycles.
REQ-017 SHOW -> BLANK after DIV_COUNT cycles; BLANK: digit_en = 0, seg_code holds the last nibble; lasts exactly BLANK_CYCLES cycles.
REQ-018 BLANK -> SHOW with index+1; index NUM_DIGITS-1 wraps to 0, which is a frame boundary.
REQ-019 Frame period = NUM_DIGITS*(DIV_COUNT+BLANK_CYCLES) cycles; counter width = clog2 of max(DIV_COUNT, BLANK_CYCLES).
REQ-020 Handshake: accepted load captures digits_in into pending; load_ready = 0 the next cycle.
REQ-021 Pending full at a frame boundary: pending -> active on the transition edge; the new value shows on the first SHOW cycle; load_ready = 1 the cycle after.
REQ-022 Pending empty at a frame boundary: active unchanged.
REQ-023 Load accepted on a frame-boundary edge, with pending empty before it: the data stays pending and commits at the following frame boundary.
REQ-024 load_valid while load_ready = 0: ignored; pending not overwritten.
REQ-025 enable = 0 in any state: IDLE on the next edge; pending contents retained.
REQ-026 frame_start pulses on every entry to SHOW with index 0, including from IDLE.

Reset
REQ-027 Reset values (immediate, asynchronous): state IDLE, index 0, counter 0, active buffer 0, pending empty, load_ready 1, digit_en 0, seg_code 0, frame_start 0.
REQ-028 Reset asserted mid-operation: all of REQ-027 applies; no partial commit; the next load after release is accepted normally.

Structure
REQ-029 Shared package display_pkg holds: scan state enum, default DIV_COUNT/BLANK_CYCLES constants, and a digit-count limit constant.
REQ-030 One sub-module, scan_timer: loadable down-counter with done flag; used for both SHOW and BLANK durations.
REQ-031 Elaboration-time assertion rejects illegal parameter values.

Verification (NUM_DIGITS=2, DIV_COUNT=4, BLANK_CYCLES=2)
REQ-032 Release reset, enable=1, no load -> digit_en 01 x4, 00 x2, 10 x4, 00 x2, repeating; frame_start every 12 cycles; seg_code 0.
REQ-033 Load 0x3A mid-frame -> load_ready=0 next cycle; next frame: digit0 seg_code=A, digit1 seg_code=3; load_ready=1 one cycle after the boundary.
REQ-034 Load 0x3A then 0x55 in the same frame -> 0x55 refused (ready=0); display shows 3/A.
REQ-035 enable=0 during digit1 SHOW -> next cycle digit_en=00, seg_code=0; enable=1 -> digit0 SHOW with frame_start pulse.
REQ-036 reset pulse during BLANK with pending full -> outputs 0 immediately, load_ready=1, active=0x00 after release.
REQ-037 Load 0x7C on the frame-boundary edge with pending empty -> display shows 0x7C from the following frame, not the current one.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared definitions for the multiplexed seven-segment scan controller:
//   scan state encoding, default timing constants, digit-count limits and a
//   small constant helper used to size the slot counter.
// -----------------------------------------------------------------------------
package display_pkg;

  // Scan FSM states. IDLE keeps every digit dark, SHOW drives one digit,
  // BLANK is the all-off gap between slots that suppresses ghosting.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // Defaults sized for a 6 MHz clock: 10 ms per digit, 100 us blanking.
  localparam int DEFAULT_DIV_COUNT    = 60000;
  localparam int DEFAULT_BLANK_CYCLES = 600;

  // Supported range of multiplexed digits.
  localparam int MIN_DIGITS = 2;
  localparam int MAX_DIGITS = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : display_pkg

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
//   Loadable down-counter that times both the SHOW and BLANK slots. Loading
//   value N-1 yields a slot of exactly N cycles: done_o is high in the last
//   cycle of the slot, when the count has reached zero.
//
// Ports
//   clk          : clock
//   reset        : asynchronous active-high reset
//   clear_i      : force the count to zero (highest priority)
//   load_i       : load load_value_i
//   load_value_i : slot length minus one
//   count_o      : current count
//   done_o       : count has reached zero
// -----------------------------------------------------------------------------
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from the same pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule : scan_timer

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexed scan controller for NUM_DIGITS seven-segment digits.
//   Each digit is lit for DIV_COUNT cycles, followed by BLANK_CYCLES cycles
//   with every digit off. New digit values arrive through a one-deep pending
//   buffer and are copied to the displayed (active) buffer only at a frame
//   boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk         : clock
//   reset       : asynchronous active-high reset
//   enable      : scanning runs while high; low returns to IDLE
//   digits_in   : new digit values, nibble k drives digit k
//   load_valid  : digits_in valid this cycle
//   load_ready  : pending buffer empty; load taken when valid && ready
//   seg_code    : nibble for the external seven-segment decoder
//   digit_en    : one-hot active-high digit enables
//   frame_start : one-cycle pulse on the first SHOW cycle of digit 0
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DIV_COUNT    = DEFAULT_DIV_COUNT,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [3:0]              seg_code,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(max_int(DIV_COUNT, BLANK_CYCLES));
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  if ((NUM_DIGITS < MIN_DIGITS) || (NUM_DIGITS > MAX_DIGITS) ||
      (DIV_COUNT < 2) || (BLANK_CYCLES < 1)) begin : g_bad_params
    $error("display_scan_ctrl: illegal parameters NUM_DIGITS=%0d DIV_COUNT=%0d BLANK_CYCLES=%0d",
           NUM_DIGITS, DIV_COUNT, BLANK_CYCLES);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  scan_state_e                state_q,  state_d;
  logic [IDX_W-1:0]           index_q,  index_d;
  logic [4*NUM_DIGITS-1:0]    active_q, active_d;
  logic [4*NUM_DIGITS-1:0]    pending_q, pending_d;
  logic                       pending_full_q, pending_full_d;

  // Timer control
  logic                       tmr_clear;
  logic                       tmr_load;
  logic [CNT_W-1:0]           tmr_value;
  logic [CNT_W-1:0]           tmr_count;
  logic                       tmr_done;

  // Asserted on the edge that enters SHOW for digit 0.
  logic                       frame_edge;
  logic                       load_accept;

  scan_timer #(
    .CNT_W (CNT_W)
  ) u_scan_timer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (tmr_clear),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .count_o      (tmr_count),
    .done_o       (tmr_done)
  );

  // ---------------------------------------------------------------------------
  // Scan sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tmr_clear  = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    frame_edge = 1'b0;

    if (!enable) begin
      state_d   = ST_IDLE;
      index_d   = '0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_SHOW;
          index_d    = '0;
          tmr_load   = 1'b1;
          tmr_value  = SHOW_LOAD;
          frame_edge = 1'b1;
        end
        ST_SHOW: begin
          if (tmr_done) begin
            state_d   = ST_BLANK;
            tmr_load  = 1'b1;
            tmr_value = BLANK_LOAD;
          end
        end
        ST_BLANK: begin
          if (tmr_done) begin
            state_d   = ST_SHOW;
            tmr_load  = 1'b1;
            tmr_value = SHOW_LOAD;
            if (index_q == LAST_IDX) begin
              index_d    = '0;
              frame_edge = 1'b1;
            end else begin
              index_d = index_q + 1'b1;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          index_d   = '0;
          tmr_clear = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load handshake and buffer commit
  // ---------------------------------------------------------------------------
  // A load can only be accepted while pending is empty, and a commit only
  // happens while pending is full, so the two never coincide: a load taken on
  // a frame edge simply waits for the next frame edge.
  assign load_ready  = !pending_full_q;
  assign load_accept = load_valid && !pending_full_q;

  always_comb begin
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;

    if (frame_edge && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end

    if (load_accept) begin
      pending_d      = digits_in;
      pending_full_d = 1'b1;
    end
  end

  // NOTE: the digit buffers are reset along with the control state because
  // the display must come up blank and a reset must discard any pending load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      index_q        <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  // BLANK keeps the index of the slot just shown, so seg_code holds the last
  // nibble there; only IDLE forces it to zero.
  always_comb begin
    digit_en = '0;
    seg_code = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index_q == IDX_W'(k)) begin
        digit_en[k] = (state_q == ST_SHOW);
        if (state_q != ST_IDLE) begin
          seg_code = active_q[4*k +: 4];
        end
      end
    end
  end

  // The count equals its load value only in the first cycle of a slot.
  assign frame_start = (state_q == ST_SHOW) && (index_q == '0) &&
                       (tmr_count == SHOW_LOAD);

endmodule : display_scan_ctrl

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Scoreboard bench for display_scan_ctrl with NUM_DIGITS=2, DIV_COUNT=4,
//   BLANK_CYCLES=2 (12-cycle frame). Stimulus pushes the expected outputs for
//   each cycle; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] digits_in;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] seg_code;
  logic [1:0] digit_en;
  logic       frame_start;

  display_scan_ctrl #(
    .NUM_DIGITS   (2),
    .DIV_COUNT    (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .digits_in   (digits_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .seg_code    (seg_code),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] den;
    logic [3:0] seg;
    logic       fs;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t  sb[$];
  exp_t  m_e;
  int    n_checks;
  int    n_pass;
  string phase;

  // Expected frame layout: digit enables per frame position, and whether the
  // high nibble (digit 1) is on seg_code at that position.
  logic [1:0] den_tbl [12];
  logic       hi_tbl  [12];

  // Expected-side state: frame position (-1 = IDLE), buffers, ready.
  int         pos;
  logic [7:0] exp_act;
  logic [7:0] exp_pend;
  logic       exp_rdy;

  // Monitor: compare every cycle for which an expectation is queued.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_checks++;
      if (digit_en === m_e.den && seg_code === m_e.seg &&
          frame_start === m_e.fs && load_ready === m_e.rdy) begin
        n_pass++;
      end else begin
        $display("FAIL %s check %0d: got digit_en=%b seg_code=%h frame_start=%b load_ready=%b, want digit_en=%b seg_code=%h frame_start=%b load_ready=%b",
                 m_e.tag, n_checks, digit_en, seg_code, frame_start, load_ready,
                 m_e.den, m_e.seg, m_e.fs, m_e.rdy);
      end
    end
  end

  // One clock of stimulus; queues the outputs expected after the next edge.
  task automatic cyc(input logic en, input logic lv, input logic [7:0] d);
    exp_t e;
    logic acc;
    acc = lv && exp_rdy;
    if (!en) begin
      pos   = -1;
      e.den = 2'b00;
      e.seg = 4'h0;
      e.fs  = 1'b0;
    end else begin
      pos = (pos < 0 || pos == 11) ? 0 : pos + 1;
      if (pos == 0 && !exp_rdy) begin
        exp_act = exp_pend;
        exp_rdy = 1'b1;
      end
      e.den = den_tbl[pos];
      e.seg = hi_tbl[pos] ? exp_act[7:4] : exp_act[3:0];
      e.fs  = (pos == 0);
    end
    if (acc) begin
      exp_pend = d;
      exp_rdy  = 1'b0;
    end
    e.rdy = exp_rdy;
    e.tag = phase;
    sb.push_back(e);
    enable     = en;
    load_valid = lv;
    digits_in  = d;
    @(negedge clk);
    #1;
  endtask

  // n cycles of enabled scanning with up to two load attempts.
  task automatic frame(input int n, input int a1, input logic [7:0] d1,
                       input int a2, input logic [7:0] d2);
    for (int i = 0; i < n; i++) begin
      if (i == a1)      cyc(1'b1, 1'b1, d1);
      else if (i == a2) cyc(1'b1, 1'b1, d2);
      else              cyc(1'b1, 1'b0, 8'h00);
    end
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge.
  task automatic pulse_reset();
    exp_t e;
    e.den = 2'b00;
    e.seg = 4'h0;
    e.fs  = 1'b0;
    e.rdy = 1'b1;
    e.tag = phase;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    sb.push_back(e);
    @(negedge clk);
    #1;
    reset    = 1'b0;
    pos      = -1;
    exp_act  = 8'h00;
    exp_pend = 8'h00;
    exp_rdy  = 1'b1;
  endtask

  initial begin
    den_tbl = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    hi_tbl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks   = 0;
    n_pass     = 0;
    pos        = -1;
    exp_act    = 8'h00;
    exp_pend   = 8'h00;
    exp_rdy    = 1'b1;
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    digits_in  = 8'h00;
    phase      = "reset_state";

    repeat (2) @(negedge clk);
    #1;
    cyc(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);

    phase = "free_run";
    frame(12, -1, 8'h00, -1, 8'h00);
    frame(12, -1, 8'h00, -1, 8'h00);

    phase = "double_load";
    frame(12, 2, 8'h3A, 5, 8'h55);
    phase = "show_3A";
    frame(12, -1, 8'h00, -1, 8'h00);

    phase = "boundary_load";
    frame(12, 0, 8'h7C, -1, 8'h00);
    phase = "show_7C";
    frame(12, -1, 8'h00, -1, 8'h00);

    phase = "disable";
    frame(8, 2, 8'h91, -1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    phase = "reenable";
    frame(12, -1, 8'h00, -1, 8'h00);

    phase = "reset_midrun";
    frame(5, 1, 8'h12, -1, 8'h00);
    pulse_reset();
    phase = "after_reset";
    frame(12, -1, 8'h00, -1, 8'h00);
    frame(12, 6, 8'h5E, -1, 8'h00);
    phase = "show_5E";
    frame(12, -1, 8'h00, -1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    repeat (4) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d expectations left unchecked, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_display_scan_ctrl
